// File: rtl/invaders_pkg.sv
// Shared definitions for the invaders playfield blocks.
//   FIELD_W  : playfield width in columns
//   X_W      : column field width
//   ROW_W    : row field width
//   LAUNCH_Y : row a freshly fired bullet appears on
//   PARK_Y   : row an idle bullet sits on (row 0 never matches an alien)
//   X_MAX    : right-most legal column
//   state_t  : player bullet FSM states
package invaders_pkg;

  localparam int FIELD_W = 20;
  localparam int X_W     = 5;
  localparam int ROW_W   = 4;

  localparam logic [ROW_W-1:0] LAUNCH_Y = 4'd14;
  localparam logic [ROW_W-1:0] PARK_Y   = 4'd0;
  localparam logic [X_W-1:0]   X_MAX    = 5'd19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  // Columns past the right edge of the field pin to the last column.
  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every SPEED clocks.
//   i_clk   : clock
//   i_reset : asynchronous active-high reset
//   i_clear : restart the count at 0 on the next edge
//   o_tick  : high for one cycle while the count sits at SPEED-1
module tick_gen #(
  parameter int SPEED = 20000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (SPEED > 1) ? $clog2(SPEED) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPEED - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = (cnt_q == CNT_MAX);
    cnt_d  = cnt_q + CNT_W'(1);
    if (i_clear || o_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/player_bullet.sv
// Player-side shooter: one bullet at a time, launched on a fire press, stepping
// up one row per tick, retired on a hit or on leaving the top row, with a
// saturating hit score.
//   i_clk_25MHz : system clock
//   i_reset     : asynchronous active-high reset
//   i_fire      : fire button level (synchronous)
//   i_player_x  : cannon column, clamped to 0..19
//   i_hit       : hit flag from the invaders block (level, edge-detected here)
//   o_bullet_x  : bullet column (held after retire)
//   o_bullet_y  : bullet row, 0 = top / parked
//   o_active    : bullet in flight
//   o_ready     : a fire press is accepted this cycle
//   o_score     : hit count, saturating at 255
//   o_dbg_state : current FSM state (IDLE=0, FLY=1, COOL=2)
// Handshake: i_fire is not a valid/ready pair; a rising edge of i_fire in a
// cycle where o_ready is high launches a shot, any other press is dropped.
module player_bullet
  import invaders_pkg::*;
#(
  parameter int SPEED    = 20000,
  parameter int COOLDOWN = 3
) (
  input  logic             i_clk_25MHz,
  input  logic             i_reset,
  input  logic             i_fire,
  input  logic [X_W-1:0]   i_player_x,
  input  logic             i_hit,
  output logic [X_W-1:0]   o_bullet_x,
  output logic [ROW_W-1:0] o_bullet_y,
  output logic             o_active,
  output logic             o_ready,
  output logic [7:0]       o_score,
  output logic [1:0]       o_dbg_state
);

  localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam state_t RETIRE_TO = (COOLDOWN > 0) ? COOL : IDLE;

  state_t             state_q, state_d;
  logic               fire_q, hit_q;
  logic [X_W-1:0]     x_q, x_d;
  logic [ROW_W-1:0]   y_q, y_d;
  logic [7:0]         score_q, score_d;
  logic [COOL_W-1:0]  cool_q, cool_d;

  logic fire_rise, hit_rise, tick, tick_clear, retire;

  assign fire_rise = i_fire & ~fire_q;
  assign hit_rise  = i_hit & ~hit_q;

  // The step counter restarts on launch and on retire so the first step and
  // the cooldown both run a full SPEED period.
  tick_gen #(.SPEED(SPEED)) u_tick (
    .i_clk   (i_clk_25MHz),
    .i_reset (i_reset),
    .i_clear (tick_clear),
    .o_tick  (tick)
  );

  // State and datapath registers.
  always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      fire_q  <= 1'b0;
      hit_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= PARK_Y;
      score_q <= '0;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      fire_q  <= i_fire;
      hit_q   <= i_hit;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
      cool_q  <= cool_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    score_d    = score_q;
    cool_d     = cool_q;
    tick_clear = 1'b0;
    retire     = 1'b0;

    case (state_q)
      IDLE: begin
        if (fire_rise) begin
          state_d    = FLY;
          x_d        = clamp_x(i_player_x);
          y_d        = LAUNCH_Y;
          tick_clear = 1'b1;
        end
      end
      FLY: begin
        // A hit beats a coincident tick: the bullet retires without stepping.
        if (hit_rise) begin
          retire = 1'b1;
          if (score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
          end
        end else if (tick && (y_q == 4'd1)) begin
          retire = 1'b1;
        end else if (tick) begin
          y_d = y_q - 4'd1;
        end
        if (retire) begin
          state_d    = RETIRE_TO;
          y_d        = PARK_Y;
          cool_d     = '0;
          tick_clear = 1'b1;
        end
      end
      COOL: begin
        if (tick) begin
          if (cool_q == COOL_LAST) begin
            state_d = IDLE;
          end else begin
            cool_d = cool_q + COOL_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    o_bullet_x  = x_q;
    o_bullet_y  = y_q;
    o_active    = (state_q == FLY);
    o_ready     = (state_q == IDLE);
    o_score     = score_q;
    o_dbg_state = state_q;
  end

endmodule
